phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, which sets the width of the completed-instruction counter.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  level; begins execution from IDLE or HALT.
REQ-005 SHALL have port stop  input  1  pulse or level; requests a stop at the next instruction boundary.
REQ-006 SHALL have port step_mode  input  1  level; 1 = pause after every instruction.
REQ-007 SHALL have port step_req  input  1  pulse; releases one instruction while in STEP.
REQ-008 SHALL have port stall  input  1  level; holds the current phase (e.g. memory wait).
REQ-009 SHALL have port halt  input  1  level from datapath; sampled only in the last P5 cycle.
REQ-010 SHALL have port fase  output  5  one-hot phase vector, bit0 = P1 .. bit4 = P5; 0 when not executing; drives the phase decoder.
REQ-011 SHALL have port running  output  1  1 while in state RUN.
REQ-012 SHALL have port halted  output  1  1 while in state HALT.
REQ-013 SHALL have port cycle_done  output  1  one-cycle pulse per completed instruction.
REQ-014 SHALL have port instr_count  output  CNT_W  count of completed instructions.

Function
REQ-015 SHALL implement the states IDLE, RUN, STEP and HALT; all outputs SHALL be registered.
REQ-016 In IDLE, start=1 SHALL enter RUN with fase=00001 on the next edge (1-cycle latency).
REQ-017 In RUN with stall=0, fase SHALL rotate P1->P2->P3->P4->P5 at one phase per cycle.
REQ-018 In RUN with stall=1, fase SHALL hold its value and no other state SHALL change except stop_pending.
REQ-019 stop=1 in any cycle of RUN SHALL set the internal flag stop_pending; the flag SHALL clear on entry to IDLE.
REQ-020 The instruction boundary is the edge leaving P5 with stall=0.
  - At that edge, cycle_done SHALL be 1 for exactly the following cycle.
  - At that edge, instr_count SHALL increment by 1, wrapping from 2^CNT_W-1 to 0.
REQ-021 The next state at the boundary SHALL be chosen with priority halt > stop_pending > step_mode > continue:
  - halt -> HALT, fase=0
  - stop_pending -> IDLE, fase=0
  - step_mode -> STEP, fase=0
  - otherwise -> stay in RUN, fase=00001
REQ-022 In STEP, step_req=1 or step_mode=0 SHALL return to RUN with fase=00001 on the next edge.
REQ-023 In STEP, stop=1 SHALL enter IDLE on the next edge; stop SHALL take priority over step_req.
REQ-024 In HALT, halted SHALL be 1 and fase SHALL be 0.
REQ-025 In HALT, start=1 SHALL enter RUN with fase=00001 and clear halted on the same edge.
REQ-026 start SHALL be ignored in RUN and STEP.
REQ-027 stop SHALL be ignored in IDLE and HALT.
REQ-028 halt SHALL be ignored outside the boundary cycle.
REQ-029 fase SHALL never have more than one bit set; outside RUN it SHALL be 00000.
REQ-030 A stall in P5 SHALL defer the boundary, cycle_done, the instr_count increment and the halt sampling until stall=0.
REQ-031 If start and stop are both 1 in IDLE, the block SHALL enter RUN with stop_pending clear; stop SHALL be ignored that cycle.

Reset
REQ-032 rst=1 SHALL immediately, without waiting for a clock edge, force:
  - state = IDLE
  - fase = 00000
  - running = 0, halted = 0, cycle_done = 0
  - instr_count = 0, stop_pending = 0
REQ-033 rst asserted mid-instruction SHALL abandon the instruction with no cycle_done and no count increment.
REQ-034 After rst deasserts, the block SHALL remain in IDLE until start=1.

Verification
REQ-035 The bench SHALL cover: start pulse in IDLE, no stall -> fase sequence 00001, 00010, 00100, 01000, 10000, 00001 ...; cycle_done one cycle after each P5; instr_count = 3 after 15 phase cycles.
REQ-036 The bench SHALL cover: stall=1 for 4 cycles during P3 -> fase holds 00100 for 5 cycles total; instr_count unaffected until P5 completes.
REQ-037 The bench SHALL cover: stop pulse during P2 -> instruction completes through P5; then IDLE, fase=0, running=0, instr_count +1.
REQ-038 The bench SHALL cover: halt=1 and stop pulse both in the P5 cycle -> HALT, halted=1; a later start -> fase=00001, halted=0.
REQ-039 The bench SHALL cover: step_mode=1 -> one instruction, then STEP with fase=0; each step_req -> exactly one more 5-phase instruction; CNT_W=4 with 17 instructions -> instr_count = 1 (wrap).
REQ-040 The bench SHALL cover: rst asserted asynchronously during P4 -> all outputs 0 before the next clock edge; no cycle_done pulse.

Source files
------------

// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer. It steps a one-hot phase vector P1..P5,
// counts completed instructions, and supports stall, stop, single-step and
// halt control. Every output is registered.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | not executing; fase = 0; waits for start
//   RUN   | executing; fase rotates P1..P5 unless stalled
//   STEP  | single-step pause after an instruction; fase = 0; waits for step_req
//   HALT  | datapath requested halt at a boundary; halted = 1; waits for start
module phase_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step_mode,
  input  logic             step_req,
  input  logic             stall,
  input  logic             halt,
  output logic [4:0]       fase,
  output logic             running,
  output logic             halted,
  output logic             cycle_done,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [4:0] PH_P1   = 5'b00001;
  localparam logic [4:0] PH_NONE = 5'b00000;

  logic [1:0] state;
  logic       stop_pending;
  logic       stop_eff;

  // A stop raised in the P5 cycle itself is honoured at that same boundary.
  assign stop_eff = stop_pending | stop;

  // Sequencer state, phase rotation, boundary decision and instruction count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      fase         <= PH_NONE;
      running      <= 1'b0;
      halted       <= 1'b0;
      cycle_done   <= 1'b0;
      instr_count  <= '0;
      stop_pending <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      case (state)
        S_IDLE: begin
          // stop is ignored here, so start+stop together simply starts.
          if (start) begin
            state   <= S_RUN;
            fase    <= PH_P1;
            running <= 1'b1;
          end
        end

        S_RUN: begin
          if (stop) stop_pending <= 1'b1;
          if (!stall) begin
            if (fase[4]) begin
              cycle_done  <= 1'b1;
              instr_count <= instr_count + CNT_W'(1);
              if (halt) begin
                state   <= S_HALT;
                fase    <= PH_NONE;
                running <= 1'b0;
                halted  <= 1'b1;
              end else if (stop_eff) begin
                state        <= S_IDLE;
                fase         <= PH_NONE;
                running      <= 1'b0;
                stop_pending <= 1'b0;
              end else if (step_mode) begin
                state   <= S_STEP;
                fase    <= PH_NONE;
                running <= 1'b0;
              end else begin
                fase <= PH_P1;
              end
            end else begin
              fase <= fase << 1;
            end
          end
        end

        S_STEP: begin
          if (stop) begin
            state        <= S_IDLE;
            stop_pending <= 1'b0;
          end else if (step_req || !step_mode) begin
            state   <= S_RUN;
            fase    <= PH_P1;
            running <= 1'b1;
          end
        end

        S_HALT: begin
          if (start) begin
            state   <= S_RUN;
            fase    <= PH_P1;
            running <= 1'b1;
            halted  <= 1'b0;
          end
        end

        default: begin
          state   <= S_IDLE;
          fase    <= PH_NONE;
          running <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer (CNT_W = 4 so the counter wrap is reachable).
module tb_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       step_mode = 1'b0;
  logic       step_req = 1'b0;
  logic       stall = 1'b0;
  logic       halt = 1'b0;
  logic [4:0] fase;
  logic       running;
  logic       halted;
  logic       cycle_done;
  logic [3:0] instr_count;

  int tests = 0;
  int fails = 0;

  phase_sequencer #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .step_mode  (step_mode),
    .step_req   (step_req),
    .stall      (stall),
    .halt       (halt),
    .fase       (fase),
    .running    (running),
    .halted     (halted),
    .cycle_done (cycle_done),
    .instr_count(instr_count)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_fase", 32'(fase), 32'h0);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_done", 32'(cycle_done), 32'h0);
    chk("rst_count", 32'(instr_count), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_fase", 32'(fase), 32'h0);

    // Free run: three full instructions and the start of a fourth
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      chk("run_fase", 32'(fase), 32'(5'b00001 << (k % 5)));
      chk("run_done", 32'(cycle_done), ((k > 0) && (k % 5 == 0)) ? 32'h1 : 32'h0);
      chk("run_count", 32'(instr_count), 32'(k / 5));
      if (k < 15) tick();
    end

    // Stall four cycles in P3
    tick();
    tick();
    chk("pre_stall_p3", 32'(fase), 32'h04);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_fase", 32'(fase), 32'h04);
      chk("stall_count", 32'(instr_count), 32'h3);
    end
    stall = 1'b0;
    tick();
    chk("post_stall_p4", 32'(fase), 32'h08);
    tick();
    chk("post_stall_p5", 32'(fase), 32'h10);
    tick();
    chk("stall_bnd_fase", 32'(fase), 32'h01);
    chk("stall_bnd_done", 32'(cycle_done), 32'h1);
    chk("stall_bnd_count", 32'(instr_count), 32'h4);

    // Stop pulse in P2: instruction completes, then IDLE
    tick();
    chk("stop_p2", 32'(fase), 32'h02);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    tick();
    chk("stop_p5_fase", 32'(fase), 32'h10);
    chk("stop_p5_running", 32'(running), 32'h1);
    tick();
    chk("stop_idle_fase", 32'(fase), 32'h0);
    chk("stop_idle_running", 32'(running), 32'h0);
    chk("stop_idle_done", 32'(cycle_done), 32'h1);
    chk("stop_idle_count", 32'(instr_count), 32'h5);
    stop = 1'b1;
    tick();
    chk("idle_stop_ignored", 32'(fase), 32'h0);
    chk("idle_done_clear", 32'(cycle_done), 32'h0);

    // start and stop together in IDLE: run without a pending stop
    start = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("startstop_fase", 32'(fase), 32'h01);
    for (int i = 0; i < 4; i++) tick();
    chk("startstop_p5", 32'(fase), 32'h10);
    tick();
    chk("startstop_cont_fase", 32'(fase), 32'h01);
    chk("startstop_cont_running", 32'(running), 32'h1);
    chk("startstop_count", 32'(instr_count), 32'h6);

    // halt and stop together in P5 -> HALT
    for (int i = 0; i < 4; i++) tick();
    chk("halt_p5", 32'(fase), 32'h10);
    halt = 1'b1;
    stop = 1'b1;
    tick();
    halt = 1'b0;
    stop = 1'b0;
    chk("halt_halted", 32'(halted), 32'h1);
    chk("halt_fase", 32'(fase), 32'h0);
    chk("halt_running", 32'(running), 32'h0);
    chk("halt_done", 32'(cycle_done), 32'h1);
    chk("halt_count", 32'(instr_count), 32'h7);
    tick();
    chk("halt_hold", 32'(halted), 32'h1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("halt_restart_fase", 32'(fase), 32'h01);
    chk("halt_restart_halted", 32'(halted), 32'h0);
    chk("halt_restart_running", 32'(running), 32'h1);

    // Asynchronous reset in P4
    tick();
    tick();
    tick();
    chk("pre_rst_p4", 32'(fase), 32'h08);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_fase", 32'(fase), 32'h0);
    chk("arst_running", 32'(running), 32'h0);
    chk("arst_halted", 32'(halted), 32'h0);
    chk("arst_done", 32'(cycle_done), 32'h0);
    chk("arst_count", 32'(instr_count), 32'h0);
    tick();
    chk("arst_edge_done", 32'(cycle_done), 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 32'(fase), 32'h0);
    chk("post_rst_running", 32'(running), 32'h0);

    // Single-step mode: 17 instructions wrap the 4-bit counter to 1
    step_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("step_first_p1", 32'(fase), 32'h01);
    for (int i = 0; i < 4; i++) tick();
    chk("step_first_p5", 32'(fase), 32'h10);
    tick();
    chk("step_pause_fase", 32'(fase), 32'h0);
    chk("step_pause_running", 32'(running), 32'h0);
    chk("step_pause_done", 32'(cycle_done), 32'h1);
    chk("step_pause_count", 32'(instr_count), 32'h1);
    tick();
    chk("step_wait_fase", 32'(fase), 32'h0);
    chk("step_wait_done", 32'(cycle_done), 32'h0);
    for (int n = 2; n <= 17; n++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      chk("step_rel_fase", 32'(fase), 32'h01);
      for (int i = 0; i < 4; i++) tick();
      chk("step_p5", 32'(fase), 32'h10);
      tick();
      chk("step_end_fase", 32'(fase), 32'h0);
      chk("step_end_done", 32'(cycle_done), 32'h1);
      chk("step_end_count", 32'(instr_count), 32'(n % 16));
    end
    chk("step_wrap_count", 32'(instr_count), 32'h1);

    // stop beats step_req in STEP; afterwards IDLE ignores step_req/step_mode
    step_req = 1'b1;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("step_stop_fase", 32'(fase), 32'h0);
    chk("step_stop_running", 32'(running), 32'h0);
    tick();
    step_req = 1'b0;
    chk("idle_stepreq_ignored", 32'(fase), 32'h0);
    step_mode = 1'b0;
    tick();
    chk("idle_stepmode_ignored", 32'(fase), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
